// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store bridge from the execute stage
// to a single-port word RAM with 1-cycle registered read and byte mask.
//
// Ports:
//   clk, resetn              clock, async active-low reset
//   req_valid/req_ready      request handshake (ready == IDLE)
//   req_we, req_funct3       store flag and RISC-V size/sign code
//   req_addr, req_wdata      byte address and right-aligned store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     extended load data / error flag
//   mem_addr, mem_ren        word-aligned RAM address, read enable
//   mem_wdata, mem_wmask     lane-replicated data, byte write enables
//   mem_rdata                RAM read data, valid after the ren edge
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1536
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_ren,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [29:0] MEM_LIM = 30'(MEM_WORDS);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        f3_ok;
    logic        misalign;
    logic        req_err;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] st_wdata;
    logic [3:0]  st_wmask;
    logic        issue;

    // Request legality, evaluated on the live request in IDLE
    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_we;
            default:                f3_ok = 1'b0;
        endcase
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err = !f3_ok || misalign || (req_addr[31:2] >= MEM_LIM);
    end

    // Load alignment and extension
    always_comb begin
        shifted = mem_rdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Store lane replication and byte mask
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                st_wdata = {4{wdata_q[7:0]}};
                st_wmask = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                st_wdata = {2{wdata_q[15:0]}};
                st_wmask = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = wdata_q;
                st_wmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'd0;
                    err_d   = req_err;
                    state_d = req_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE:   state_d = we_q ? S_RESP : S_CAPTURE;
            S_CAPTURE: begin
                rdata_d = load_ext;
                state_d = S_RESP;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM strobes decode straight from the state register so an async
    // reset during ISSUE kills the write mask before the next edge.
    assign issue      = (state_q == S_ISSUE);
    assign mem_ren    = issue && !we_q;
    assign mem_wmask  = (issue && we_q) ? st_wmask : 4'b0000;
    assign mem_wdata  = (issue && we_q) ? st_wdata : 32'd0;
    assign mem_addr   = issue ? {addr_q[31:2], 2'b00} : 32'd0;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: RAM model, reference model, scoreboard.
// Directed cases followed by randomized traffic.
module tb_load_store_unit;

    localparam int MW = 1536;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_ren(mem_ren),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata)
    );

    logic [31:0] ram     [0:MW-1];
    logic [31:0] ref_mem [0:MW-1];

    // Data RAM: registered read, per-byte write, no reset
    int ram_wi;
    always @(posedge clk) begin
        ram_wi = int'(mem_addr[31:2]);
        if (ram_wi < MW) begin
            if (mem_ren) mem_rdata <= ram[ram_wi];
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) ram[ram_wi][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          acc_cnt;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } item_t;

    item_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accesses = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: decides legality, response data and store lanes
    // directly from the ISA rules, and applies stores to ref_mem.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd,
                                  output logic [3:0] mask,
                                  output logic [31:0] wdr);
        int unsigned w;
        int unsigned off;
        int size;
        bit legal;
        logic [31:0] x;
        w   = a >> 2;
        off = a % 4;
        legal = we ? (f3 <= 3'd2)
                   : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err  = !legal || (off % size != 0) || (w >= MW);
        rd = 32'd0; mask = 4'd0; wdr = 32'd0;
        if (!err) begin
            if (we) begin
                if (size == 1) begin
                    mask = 4'b0001 << off;
                    wdr  = {24'd0, wd[7:0]} * 32'h01010101;
                end else if (size == 2) begin
                    mask = 4'b0011 << off;
                    wdr  = {16'd0, wd[15:0]} * 32'h00010001;
                end else begin
                    mask = 4'hF;
                    wdr  = wd;
                end
                for (int i = 0; i < 4; i++)
                    if (mask[i]) ref_mem[w][8*i +: 8] = wdr[8*i +: 8];
            end else begin
                x = ref_mem[w] >> (8 * off);
                if (size == 1) begin
                    rd = x & 32'hFF;
                    if (!f3[2] && x[7]) rd = rd | 32'hFFFFFF00;
                end else if (size == 2) begin
                    rd = x & 32'hFFFF;
                    if (!f3[2] && x[15]) rd = rd | 32'hFFFF0000;
                end else begin
                    rd = x;
                end
            end
        end
    endfunction

    // Monitor: checks every RAM access against the in-flight request
    // and every response against the scoreboard head.
    item_t mit;
    always @(negedge clk) begin
        if (resetn) begin
            if (mem_ren || mem_wmask != 4'd0) begin
                accesses++;
                if (q.size() == 0) begin
                    check("access_without_request", 32'd1, 32'd0);
                end else begin
                    mit = q[0];
                    check("access_on_error_req", {31'd0, mit.err}, 32'd0);
                    check("access_ren", {31'd0, mem_ren}, {31'd0, !mit.we});
                    check("access_addr", mem_addr, {mit.addr[31:2], 2'b00});
                    if (mit.we) begin
                        check("store_wmask", {28'd0, mem_wmask}, {28'd0, mit.mask});
                        check("store_wdata", mem_wdata, mit.wdata);
                    end else begin
                        check("load_wmask", {28'd0, mem_wmask}, 32'd0);
                    end
                end
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    check("spurious_resp", 32'd1, 32'd0);
                end else begin
                    mit = q.pop_front();
                    check("resp_rdata", resp_rdata, mit.rdata);
                    check("resp_err", {31'd0, resp_err}, {31'd0, mit.err});
                    check("resp_latency", cyc - mit.acc, mit.lat);
                    check("ram_accesses", accesses - mit.acc_cnt,
                          mit.err ? 0 : 1);
                    check("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
                end
            end
        end
    end

    task automatic send(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit hold, input bit use_k,
                        input logic [31:0] k);
        item_t it;
        bit ok;
        logic e;
        logic [31:0] rd;
        logic [3:0] m;
        logic [31:0] wdr;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        model(we, f3, a, wd, e, rd, m, wdr);
        it.rdata   = use_k ? k : rd;
        it.err     = e;
        it.lat     = e ? 1 : (we ? 2 : 3);
        it.acc     = cyc;
        it.acc_cnt = accesses;
        it.we      = we;
        it.addr    = a;
        it.wdata   = wdr;
        it.mask    = m;
        q.push_back(it);
        @(posedge clk);
        if (!hold) begin
            #1 req_valid = 1'b0;
        end
    endtask

    logic [31:0] old_w;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] ra;
    int          sel;

    initial begin
        for (int i = 0; i < MW; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[100] = 32'h04030201; ref_mem[100] = 32'h04030201;
        ram[103] = 32'hFF0F0E0D; ref_mem[103] = 32'hFF0F0E0D;

        // Reset state, with a request offered that must not be captured
        req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h190;
        #12;
        check("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
        check("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {31'd0, req_ready}, 32'd1);

        // Directed loads
        send(1'b0, 3'b010, 32'h190, 32'd0, 1'b0, 1'b1, 32'h04030201);
        send(1'b0, 3'b000, 32'h19F, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFF);
        send(1'b0, 3'b100, 32'h19F, 32'd0, 1'b0, 1'b1, 32'h000000FF);
        send(1'b0, 3'b001, 32'h19E, 32'd0, 1'b0, 1'b1, 32'hFFFFFF0F);
        send(1'b0, 3'b101, 32'h19C, 32'd0, 1'b0, 1'b1, 32'h00000E0D);

        // Byte store then readback
        send(1'b1, 3'b000, 32'h191, 32'h000000AB, 1'b0, 1'b1, 32'd0);
        send(1'b0, 3'b010, 32'h190, 32'd0, 1'b0, 1'b1, 32'h0403AB01);

        // Errors
        send(1'b0, 3'b010, 32'h192, 32'd0, 1'b0, 1'b1, 32'd0);
        send(1'b1, 3'b001, 32'h193, 32'h1234, 1'b0, 1'b1, 32'd0);
        send(1'b0, 3'b010, 32'h1800, 32'd0, 1'b0, 1'b1, 32'd0);
        send(1'b0, 3'b011, 32'h190, 32'd0, 1'b0, 1'b1, 32'd0);

        // Back-to-back loads with req_valid held high
        send(1'b0, 3'b010, 32'h190, 32'd0, 1'b1, 1'b0, 32'd0);
        send(1'b0, 3'b010, 32'h19C, 32'd0, 1'b1, 1'b0, 32'd0);
        send(1'b0, 3'b001, 32'h196, 32'd0, 1'b1, 1'b0, 32'd0);
        send(1'b0, 3'b000, 32'h199, 32'd0, 1'b0, 1'b0, 32'd0);

        // Reset during the ISSUE cycle of a word store
        old_w = ref_mem[100];
        send(1'b1, 3'b010, 32'h190, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        check("abort_issue_wmask", {28'd0, mem_wmask}, 32'hF);
        #1 resetn = 1'b0;
        q.delete();
        ref_mem[100] = old_w;
        #1;
        check("abort_wmask_dropped", {28'd0, mem_wmask}, 32'd0);
        check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_resp_later", {31'd0, resp_valid}, 32'd0);
        resetn = 1'b1;
        send(1'b0, 3'b010, 32'h190, 32'd0, 1'b0, 1'b1, 32'h0403AB01);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            rwe = 1'($urandom % 2);
            rf3 = 3'($urandom % 8);
            sel = int'($urandom % 8);
            if (sel < 6)       ra = 32'h180 + ($urandom % 64);
            else if (sel == 6) ra = 32'h17FC + ($urandom % 8);
            else               ra = $urandom;
            send(rwe, rf3, ra, $urandom,
                 (i != 149) && ($urandom % 2 == 1), 1'b0, 32'd0);
        end

        for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
        check("scoreboard_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the single-port 1536-word data RAM (1-cycle registered read, per-byte write mask, no reset).
- Accepts one load/store request at a time from the core.
- Checks alignment and range, builds the byte-lane write mask and replicated write data, and drives the RAM for exactly one cycle.
- For loads, extracts the addressed byte, half or word and zero- or sign-extends it, then returns a one-cycle response.

Parameters:
- MEM_WORDS, 1536: RAM depth in 32-bit words. Any access with addr[31:2] >= MEM_WORDS is an error.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  core request strobe
- req_ready  out  1  unit idle and able to accept; combinational, equals (state==IDLE)
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, out-of-range or illegal funct3
- mem_addr  out  32  RAM byte address, word-aligned (low 2 bits 0)
- mem_ren  out  1  RAM read enable
- mem_wdata  out  32  RAM write data, lane-replicated
- mem_wmask  out  4  RAM byte write enables
- mem_rdata  in  32  RAM read data, valid the cycle after the mem_ren edge

Behaviour:
- Reset (resetn low, asynchronous):
  - State forced to IDLE.
  - mem_ren, mem_wmask, mem_addr, mem_wdata, resp_valid, resp_rdata and resp_err are all 0.
  - req_ready reads 1 during reset, but no request is captured while resetn is low.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: a request is accepted when req_valid is high at a clk edge. The request fields are registered at that edge.
  - Error request: go to RESP with resp_err=1. No RAM access occurs.
  - Store: go to ISSUE and drive the store.
  - Load: go to ISSUE and drive the read.
- Error conditions:
  - Illegal funct3: loads allow only 000/001/010/100/101; stores allow only 000/001/010.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:2] >= MEM_WORDS.
- ISSUE (one cycle): mem_addr = {addr[31:2],2'b00}.
  - Load: mem_ren=1. Next state is CAPTURE.
  - Store: mem_wmask nonzero. Next state is RESP.
  - mem_ren and mem_wmask are 0 in every state other than ISSUE. The RAM writes whenever the mask is nonzero, so this is mandatory.
- Store lanes:
  - SB: wdata = {4{b}}, wmask = 4'b0001 << addr[1:0].
  - SH: wdata = {2{h}}, wmask = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata as given, wmask = 4'b1111.
- CAPTURE: mem_rdata is shifted right by 8*addr[1:0], then:
  - LB/LH are sign-extended from bit 7/15.
  - LBU/LHU are zero-extended.
  - LW passes through.
  - The result is registered into resp_rdata; next state is RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold until the next response and are cleared when the next request is accepted.
- Latency, from accept edge to resp_valid:
  - Load: 3 cycles.
  - Store: 2 cycles.
  - Error: 1 cycle.
- Throughput: one request per 2/3/4 cycles.
- req_valid while not IDLE is ignored; the core must hold the request until it sees req_ready.
- Reset asserted mid-operation: the operation is aborted with no response. If reset asserts before the ISSUE edge, mem_wmask drops asynchronously and no partial write occurs.

Test Plan:
- Bench preloads RAM word 100 (0x190) = 0x04030201.
  - LW 0x190 -> resp_rdata=0x04030201, resp_err=0, resp_valid exactly 3 cycles after accept.
- Bench preloads word 103 (0x19C) = 0xFF0F0E0D.
  - LB 0x19F -> 0xFFFFFFFF.
  - LBU 0x19F -> 0x000000FF.
  - LH 0x19E -> 0xFFFFFF0F.
  - LHU 0x19C -> 0x00000E0D.
- SB 0x191 with wdata 0xAB:
  - ISSUE shows mem_wmask=0010, mem_wdata=0xABABABAB.
  - Response after 2 cycles.
  - A following LW 0x190 returns 0x0403AB01.
- Errors, each giving resp_err=1 one cycle after accept with mem_ren=0 and mem_wmask=0 throughout:
  - LW 0x192.
  - SH 0x193.
  - LW 0x1800 (word 1536).
  - funct3=011 load.
- Hold req_valid high continuously with back-to-back loads:
  - req_ready is low in ISSUE/CAPTURE/RESP.
  - Exactly one access per 4-cycle window; no mem_ren outside ISSUE.
- Pull resetn low during the ISSUE cycle of SW 0x190 = 0xDEADBEEF (asserted before the edge):
  - mem_wmask goes 0 immediately.
  - No resp_valid.
  - After reset, LW 0x190 returns the old value.
